// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the 2-input gate self-tester.
package gate_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int NUM_VEC = 4;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;

   function automatic int settle_w(input int s);
      return (s < 2) ? 1 : $clog2(s + 1);
   endfunction

endpackage

// File: rtl/gate_tester_if.sv
// Bundle between the tester and the gate/board side.
interface gate_tester_if;

   logic       start;
   logic       a;
   logic       b;
   logic       y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_mask;
   logic [1:0] vec_idx;

   modport master (
      input  start, y,
      output a, b, busy, done, pass, err_mask, vec_idx
   );

   modport slave (
      output start, y,
      input  a, b, busy, done, pass, err_mask, vec_idx
   );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter; holds at zero instead of wrapping.
module settle_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_tester.sv
// Walks {a,b} through all four vectors, samples y after a
// settle delay and compares against the expected truth table.
module gate_tester
   import gate_pkg::*;
#(
   parameter logic [3:0] EXPECT_TT = TT_AND,
   parameter int         SETTLE    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   gate_tester_if.master bus
);

   localparam int SETTLE_W = settle_w(SETTLE);
   localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);
   localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

   state_e     state_q;
   logic [1:0] vec_q;
   logic [3:0] err_q;
   logic [3:0] err_d;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic       load;
   logic       zero;

   // Mask including the vector being sampled this edge.
   always_comb begin
      err_d = err_q;
      err_d[vec_q] = (bus.y != EXPECT_TT[vec_q]);
   end

   assign load = (state_q == ST_IDLE && bus.start)
              || (state_q == ST_RUN && zero
                  && vec_q != LAST_VEC);

   settle_timer #(
      .W(SETTLE_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (SETTLE_V),
      .zero     (zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q <= ST_RUN;
                  vec_q   <= '0;
                  err_q   <= '0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (zero) begin
                  err_q <= err_d;
                  if (vec_q == LAST_VEC) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= ~|err_d;
                  end else begin
                     vec_q <= vec_q + 2'd1;
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.a        = vec_q[1];
   assign bus.b        = vec_q[0];
   assign bus.vec_idx  = vec_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pass     = pass_q;
   assign bus.err_mask = err_q;

endmodule
